// File: rtl/bus_mailbox_pkg.sv
// Shared definitions for the bus mailbox: register map, STATUS/CTRL bit positions,
// the STATUS word layout and the byte-enable write mask.
package bus_mailbox_pkg;
    localparam logic [1:0] MB_DATA   = 2'd0;
    localparam logic [1:0] MB_STATUS = 2'd1;
    localparam logic [1:0] MB_COUNT  = 2'd2;
    localparam logic [1:0] MB_CTRL   = 2'd3;

    localparam int ST_RX_UNF      = 4;
    localparam int ST_TX_OVF      = 5;
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_RX_FLUSH  = 8;
    localparam int CTRL_TX_FLUSH  = 9;

    // Packed MSB-first so it drops straight into STATUS bits [6:0].
    typedef struct packed {
        logic irq;
        logic tx_ovf;
        logic rx_unf;
        logic tx_full;
        logic tx_empty;
        logic rx_full;
        logic rx_empty;
    } mb_status_t;

    function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/bus_mailbox_sync_fifo.sv
// Single-clock FIFO with occupancy count; pop-before-push lets a full FIFO accept a word
// in the same cycle one leaves. Flush overrides any same-cycle push or pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/bus_mailbox.sv
// CPU-facing mailbox: RX stream -> DATA reads, DATA writes -> TX stream, with sticky
// under/overflow flags, irq enables and per-FIFO flush.
module bus_mailbox
    import bus_mailbox_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter bit FULL_STALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    input  logic [3:0]  be,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        irq,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rd_ack, rx_unf, tx_ovf, rx_irq_en, tx_irq_en;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0] rx_count, tx_count;
    logic [31:0]   rx_head, rd_val;
    logic          rd_start, data_rd, data_wr, ctrl_wr, stat_wr;
    logic          rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush;
    logic          wr_stall, unf_evt, ovf_evt;
    mb_status_t    status;

    // rd_ack marks the second (data) cycle; toggling it makes held-high reads restart.
    assign rd_start = read & ~rd_ack;
    assign data_rd  = rd_start & (address == MB_DATA);
    assign data_wr  = write & (address == MB_DATA);
    assign ctrl_wr  = write & (address == MB_CTRL);
    assign stat_wr  = write & (address == MB_STATUS) & be[0];

    assign wr_stall    = FULL_STALL && data_wr && tx_full;
    assign waitrequest = rst_n & (rd_start | wr_stall);

    assign rx_push  = in_valid & ~rx_full;
    assign rx_pop   = data_rd & ~rx_empty;
    assign unf_evt  = data_rd & rx_empty;
    assign tx_push  = data_wr & ~tx_full & (be != 4'b0000);
    assign tx_pop   = out_ready & ~tx_empty;
    assign ovf_evt  = !FULL_STALL && data_wr && tx_full && (be != 4'b0000);
    assign rx_flush = ctrl_wr & be[1] & writedata[CTRL_RX_FLUSH];
    assign tx_flush = ctrl_wr & be[1] & writedata[CTRL_TX_FLUSH];

    assign in_ready  = ~rx_full;
    assign out_valid = ~tx_empty;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .wdata(in_data), .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .wdata(mask_bytes(writedata, be)), .head(out_data), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    always_comb begin
        status = '{irq: irq, tx_ovf: tx_ovf, rx_unf: rx_unf, tx_full: tx_full,
                   tx_empty: tx_empty, rx_full: rx_full, rx_empty: rx_empty};
        rd_val = '0;
        case (address)
            MB_DATA:   rd_val = rx_empty ? 32'h0 : rx_head;
            MB_STATUS: rd_val = {25'h0, status};
            MB_COUNT:  rd_val = {16'(tx_count), 16'(rx_count)};
            MB_CTRL:   rd_val = {30'h0, tx_irq_en, rx_irq_en};
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack    <= 1'b0;
            readdata  <= '0;
            rx_unf    <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            rd_ack <= rd_start;
            if (rd_start) readdata <= rd_val;
            // A new event in the same cycle as its W1C keeps the flag set.
            rx_unf <= unf_evt | (rx_unf & ~(stat_wr & writedata[ST_RX_UNF]));
            tx_ovf <= ovf_evt | (tx_ovf & ~(stat_wr & writedata[ST_TX_OVF]));
            if (ctrl_wr && be[0]) begin
                rx_irq_en <= writedata[CTRL_RX_IRQ_EN];
                tx_irq_en <= writedata[CTRL_TX_IRQ_EN];
            end
            irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
        end
    end
endmodule

// File: tb/tb_bus_mailbox.sv
// Bench for bus_mailbox: two instances (stalling and dropping TX) sharing one stimulus bus,
// checked against a queue-based model of the mailbox.
module tb_bus_mailbox;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0;  // 1: talk to the FULL_STALL=0 instance
    logic        read, write, in_valid, out_ready;
    logic [1:0]  address;
    logic [31:0] writedata, in_data;
    logic [3:0]  be;

    logic [31:0] rd_s, rd_d, od_s, od_d;
    logic        wt_s, wt_d, irq_s, irq_d, ir_s, ir_d, ov_s, ov_d;
    logic [31:0] readdata, out_data;
    logic        waitrequest, irq, in_ready, out_valid;

    int checks = 0;
    int errors = 0;

    int unsigned rxq[$];
    int unsigned txq[$];
    bit m_unf, m_ovf, m_rx_en, m_tx_en;

    always #5 clk = ~clk;

    bus_mailbox #(.DEPTH(DEPTH), .FULL_STALL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .read(read & ~sel0), .write(write & ~sel0),
        .address(address), .writedata(writedata), .be(be), .readdata(rd_s),
        .waitrequest(wt_s), .irq(irq_s), .in_data(in_data), .in_valid(in_valid & ~sel0),
        .in_ready(ir_s), .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready & ~sel0)
    );

    bus_mailbox #(.DEPTH(DEPTH), .FULL_STALL(1'b0)) dut_drop (
        .clk(clk), .rst_n(rst_n), .read(read & sel0), .write(write & sel0),
        .address(address), .writedata(writedata), .be(be), .readdata(rd_d),
        .waitrequest(wt_d), .irq(irq_d), .in_data(in_data), .in_valid(in_valid & sel0),
        .in_ready(ir_d), .out_data(od_d), .out_valid(ov_d), .out_ready(out_ready & sel0)
    );

    assign readdata    = sel0 ? rd_d  : rd_s;
    assign waitrequest = sel0 ? wt_d  : wt_s;
    assign irq         = sel0 ? irq_d : irq_s;
    assign in_ready    = sel0 ? ir_d  : ir_s;
    assign out_data    = sel0 ? od_d  : od_s;
    assign out_valid   = sel0 ? ov_d  : ov_s;

    function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_status();
        int unsigned v;
        v = 0;
        if (rxq.size() == 0)     v += 1;
        if (rxq.size() == DEPTH) v += 2;
        if (txq.size() == 0)     v += 4;
        if (txq.size() == DEPTH) v += 8;
        if (m_unf)               v += 16;
        if (m_ovf)               v += 32;
        return v;
    endfunction

    function automatic logic [31:0] exp_count();
        return (txq.size() << 16) + rxq.size();
    endfunction

    function automatic logic exp_irq();
        return (m_rx_en && rxq.size() != 0) || (m_tx_en && txq.size() == 0);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; read = 0; write = 0; address = 0; writedata = 0; be = 0;
        in_data = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rxq.delete(); txq.delete();
        m_unf = 0; m_ovf = 0; m_rx_en = 0; m_tx_en = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output int stall);
        int n = 0;
        @(posedge clk); #1;
        read = 1'b1; address = a;
        @(negedge clk);
        while (waitrequest === 1'b1 && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (waitrequest !== 1'b0) begin
            errors++; $display("FAIL read_timeout addr=%0d waitrequest=%b want 0", a, waitrequest);
        end
        d = readdata; stall = n;
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b,
                             output int stall);
        int n = 0;
        @(posedge clk); #1;
        write = 1'b1; address = a; writedata = d; be = b;
        @(negedge clk);
        while (waitrequest === 1'b1 && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (waitrequest !== 1'b0) begin
            errors++; $display("FAIL write_timeout addr=%0d waitrequest=%b want 0", a, waitrequest);
        end
        stall = n;
        @(posedge clk); #1;
        write = 1'b0; be = 4'h0;
    endtask

    task automatic stream_in(input logic [31:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        checks++;
        if (in_ready !== (rxq.size() < DEPTH)) begin
            errors++; $display("FAIL in_ready got=%b want=%b", in_ready, rxq.size() < DEPTH);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rxq.size() < DEPTH) rxq.push_back(d);
    endtask

    task automatic drain_one();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== (txq.size() > 0)) begin
            errors++; $display("FAIL out_valid got=%b want=%b", out_valid, txq.size() > 0);
        end
        if (txq.size() > 0) begin
            checks++;
            if (out_data !== txq[0]) begin
                errors++; $display("FAIL out_data got=%h want=%h", out_data, txq[0]);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (txq.size() > 0) void'(txq.pop_front());
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] want);
        logic [31:0] d;
        int st;
        bus_read(a, d, st);
        checks++;
        if (d !== want) begin errors++; $display("FAIL %s got=%h want=%h", name, d, want); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int st;
        sel0 = 1'b0;
        do_reset();
        checks++;
        if ({readdata, irq, in_ready, out_valid, waitrequest} !== {32'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h irq=%b ir=%b ov=%b wr=%b want 0/0/1/0/0",
                     readdata, irq, in_ready, out_valid, waitrequest);
        end
        bus_read(2'd1, d, st);
        checks++;
        if (d !== 32'h5 || st != 1) begin
            errors++; $display("FAIL reset_status got=%h stall=%0d want=00000005 stall=1", d, st);
        end
        chk_reg("reset_count", 2'd2, 32'h0);
    endtask

    task automatic test_reset_mid();
        sel0 = 1'b0;
        do_reset();
        stream_in(32'h1234_5678);
        @(posedge clk); #1;
        read = 1'b1; address = 2'd0;
        @(negedge clk);
        checks++;
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL mid_wait_pre got=%b want 1", waitrequest); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (waitrequest !== 1'b0 || readdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset got wait=%b rd=%h want 0/0", waitrequest, readdata);
        end
        read = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rxq.delete(); txq.delete();
        m_unf = 0; m_ovf = 0; m_rx_en = 0; m_tx_en = 0;
        chk_reg("mid_count", 2'd2, 32'h0);
    endtask

    task automatic test_rx_basic();
        int st;
        sel0 = 1'b0;
        do_reset();
        stream_in(32'h11);
        stream_in(32'h22);
        chk_reg("rx_first", 2'd0, 32'h11);
        chk_reg("rx_second", 2'd0, 32'h22);
        chk_reg("rx_underflow", 2'd0, 32'h0);
        rxq.delete(); m_unf = 1;
        chk_reg("status_unf", 2'd1, exp_status());
        bus_write(2'd1, 32'h10, 4'h1, st);
        m_unf = 0;
        chk_reg("status_w1c", 2'd1, exp_status());
    endtask

    task automatic test_tx_stall();
        int st;
        logic [31:0] w;
        sel0 = 1'b0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom; bus_write(2'd0, w, 4'hF, st); txq.push_back(w);
        end
        chk_reg("stall_count_full", 2'd2, exp_count());
        chk_reg("stall_status_full", 2'd1, exp_status());
        w = $urandom;
        @(posedge clk); #1;
        write = 1'b1; address = 2'd0; writedata = w; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (waitrequest !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got=%b want 1", i, waitrequest); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_data !== txq[0] || waitrequest !== 1'b1) begin
            errors++; $display("FAIL stall_pop got=%h wait=%b want=%h wait=1", out_data, waitrequest, txq[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        void'(txq.pop_front());
        @(negedge clk);
        checks++;
        if (waitrequest !== 1'b0) begin errors++; $display("FAIL stall_release got=%b want 0", waitrequest); end
        @(posedge clk); #1;
        write = 1'b0; be = 4'h0;
        txq.push_back(w);
        chk_reg("stall_count_after", 2'd2, exp_count());
        for (int i = 0; i < DEPTH; i++) drain_one();
        chk_reg("stall_status_end", 2'd1, exp_status());
    endtask

    task automatic test_tx_drop();
        int st;
        logic [31:0] w;
        sel0 = 1'b1;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            w = $urandom; bus_write(2'd0, w, 4'hF, st);
            if (txq.size() < DEPTH) txq.push_back(w); else m_ovf = 1;
        end
        checks++;
        if (st != 0) begin errors++; $display("FAIL drop_no_stall got=%0d want 0", st); end
        chk_reg("drop_status_ovf", 2'd1, exp_status());
        for (int i = 0; i <= DEPTH; i++) drain_one();
        bus_write(2'd1, 32'h20, 4'h1, st);
        m_ovf = 0;
        chk_reg("drop_status_w1c", 2'd1, exp_status());
        sel0 = 1'b0;
    endtask

    task automatic test_byte_enable();
        int st;
        sel0 = 1'b0;
        do_reset();
        bus_write(2'd0, 32'hAABBCCDD, 4'b0101, st);
        txq.push_back(keep_bytes(32'hAABBCCDD, 4'b0101));
        bus_write(2'd0, 32'h12345678, 4'b0000, st);
        chk_reg("be_zero_count", 2'd2, exp_count());
        checks++;
        if (out_data !== 32'h00BB00DD) begin errors++; $display("FAIL be_mask got=%h want=00bb00dd", out_data); end
        drain_one();
        drain_one();
    endtask

    task automatic test_irq();
        int st;
        sel0 = 1'b0;
        do_reset();
        bus_write(2'd3, 32'h1, 4'h1, st);
        m_rx_en = 1;
        stream_in(32'hCAFE0001);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag got=%b want 0", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b want 1", irq); end
        @(posedge clk); #1;
        write = 1'b1; address = 2'd3; writedata = 32'h0000_0101; be = 4'b0011;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        write = 1'b0; in_valid = 1'b0; be = 4'h0;
        rxq.delete();
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_flush got=%b want 0", irq); end
        chk_reg("flush_count", 2'd2, exp_count());
        chk_reg("ctrl_readback", 2'd3, 32'h1);
    endtask

    task automatic test_random();
        int st;
        int op;
        logic [31:0] d, want;
        sel0 = 1'b0;
        do_reset();
        bus_write(2'd3, 32'h3, 4'h1, st);
        m_rx_en = 1; m_tx_en = 1;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: stream_in($urandom);
                2: begin
                    if (rxq.size() > 0) want = rxq.pop_front();
                    else begin want = 0; m_unf = 1; end
                    bus_read(2'd0, d, st);
                    checks++;
                    if (d !== want) begin errors++; $display("FAIL rand_data it=%0d got=%h want=%h", it, d, want); end
                end
                3: begin
                    if (txq.size() < DEPTH) begin
                        d = $urandom; bus_write(2'd0, d, 4'hF, st); txq.push_back(d);
                    end else drain_one();
                end
                4: drain_one();
                default: chk_reg("rand_count", 2'd2, exp_count());
            endcase
            @(posedge clk); #1;
            checks++;
            if (irq !== exp_irq()) begin errors++; $display("FAIL rand_irq it=%0d got=%b want=%b", it, irq, exp_irq()); end
        end
        chk_reg("rand_status", 2'd1, exp_status() | (exp_irq() ? 32'h40 : 32'h0));
    endtask

    initial begin
        sel0 = 1'b0;
        test_reset();
        test_reset_mid();
        test_rx_basic();
        test_tx_stall();
        test_tx_drop();
        test_byte_enable();
        test_irq();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
